ddr_port_sequencer: RTL

Request sequencer between a host-side stream (FPGALink channel logic) and one Spartan-6 MCB user port (`c3_p0_*` of `ddr_interface`). It accepts write and read requests with 64-bit data streams, fills the MCB write FIFO, issues write and read commands, and drains the MCB read FIFO back to the host side under valid/ready flow control. It replaces hand-written fixed-pattern test sequences with a reusable, back-pressured front end.

---
 rtl/ddr_port_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ddr_port_sequencer.sv
// Front end for one Spartan-6 MCB user port: turns host write/read requests with
// 64-bit data streams into MCB FIFO traffic and commands, all under valid/ready.
module ddr_port_sequencer #(
  parameter int MAX_BL  = 32,
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        calib_done,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [29:0] req_addr,
  input  logic [5:0]  req_len,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [63:0] wdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [63:0] rdata,
  output logic        mcb_cmd_en,
  output logic [2:0]  mcb_cmd_instr,
  output logic [5:0]  mcb_cmd_bl,
  output logic [29:0] mcb_cmd_byte_addr,
  input  logic        mcb_cmd_full,
  output logic        mcb_wr_en,
  output logic [63:0] mcb_wr_data,
  output logic [7:0]  mcb_wr_mask,
  input  logic        mcb_wr_full,
  output logic        mcb_rd_en,
  input  logic [63:0] mcb_rd_data,
  input  logic        mcb_rd_empty,
  output logic        busy,
  output logic        err_req,
  output logic        err_timeout
);

  localparam logic [2:0] S_WAIT_CAL = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_WFILL    = 3'd2;
  localparam logic [2:0] S_WCMD     = 3'd3;
  localparam logic [2:0] S_RCMD     = 3'd4;
  localparam logic [2:0] S_RDRAIN   = 3'd5;

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [6:0]      MAX_LEN = 7'(MAX_BL);

  logic [1:0]      cal_q;
  logic [2:0]      state_q, state_d;
  logic [5:0]      len_q, len_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [5:0]      bl_q, bl_d;
  logic [29:0]     addr_q, addr_d;
  logic            err_req_q, err_req_d;
  logic            err_to_q, err_to_d;
  logic            req_legal;

  assign req_legal = (req_addr[2:0] == 3'b000) && (req_len != 6'd0) &&
                     ({1'b0, req_len} <= MAX_LEN);

  // Handshakes are pure decodes of the registered state so nothing leaks out of WAIT_CAL.
  assign req_ready         = (state_q == S_IDLE) && cal_q[1];
  assign wdata_ready       = (state_q == S_WFILL) && !mcb_wr_full;
  assign mcb_wr_en         = wdata_ready && wdata_valid;
  assign mcb_wr_data       = wdata;
  assign mcb_wr_mask       = 8'h00;
  assign mcb_cmd_en        = ((state_q == S_WCMD) || (state_q == S_RCMD)) && !mcb_cmd_full;
  assign mcb_cmd_instr     = (state_q == S_RCMD) ? 3'b001 : 3'b000;
  assign mcb_cmd_bl        = bl_q;
  assign mcb_cmd_byte_addr = addr_q;
  assign rdata_valid       = (state_q == S_RDRAIN) && !mcb_rd_empty;
  assign rdata             = mcb_rd_data;
  assign mcb_rd_en         = rdata_valid && rdata_ready;
  assign busy              = (state_q != S_IDLE) && (state_q != S_WAIT_CAL);
  assign err_req           = err_req_q;
  assign err_timeout       = err_to_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    bl_d      = bl_q;
    addr_d    = addr_q;
    err_req_d = err_req_q;
    err_to_d  = err_to_q;
    case (state_q)
      S_WAIT_CAL: if (cal_q[1]) state_d = S_IDLE;
      S_IDLE: begin
        if (!cal_q[1]) begin
          state_d = S_WAIT_CAL;
        end else if (req_valid) begin
          len_d  = req_len;
          addr_d = req_addr;
          bl_d   = req_len - 6'd1;
          cnt_d  = 6'd0;
          to_d   = '0;
          if (!req_legal)     err_req_d = 1'b1;
          else if (req_write) state_d   = S_WFILL;
          else                state_d   = S_RCMD;
        end
      end
      S_WFILL: begin
        if (mcb_wr_en) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == len_q - 6'd1) state_d = S_WCMD;
        end
      end
      S_WCMD: if (mcb_cmd_en) state_d = S_IDLE;
      S_RCMD: if (mcb_cmd_en) state_d = S_RDRAIN;
      S_RDRAIN: begin
        // Idle cycles count toward the timeout; any transferred word restarts it.
        if (mcb_rd_en) begin
          cnt_d = cnt_q + 6'd1;
          to_d  = '0;
          if (cnt_q == len_q - 6'd1) state_d = S_IDLE;
        end else if (to_q == TO_LAST) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = S_WAIT_CAL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cal_q     <= 2'b00;
      state_q   <= S_WAIT_CAL;
      len_q     <= 6'd0;
      cnt_q     <= 6'd0;
      to_q      <= '0;
      bl_q      <= 6'd0;
      addr_q    <= 30'd0;
      err_req_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      cal_q     <= {cal_q[0], calib_done};
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      bl_q      <= bl_d;
      addr_q    <= addr_d;
      err_req_q <= err_req_d;
      err_to_q  <= err_to_d;
    end
  end

endmodule
